// File: rtl/div_pipe_if.sv
// div_pipe_if: operand/result handshake bundle for div_pipe; DIV_PIPE_DBZ_FLAG_EN adds out_dbz/out_ovf
interface div_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic in_valid, in_ready, in_signed, flush, out_valid, out_ready;
  logic [WIDTH-1:0] in_s, in_t, out_q, out_r;
  logic [TAG_W-1:0] in_tag, out_tag;
`ifdef DIV_PIPE_DBZ_FLAG_EN
  logic out_dbz, out_ovf;
  modport master (
    output in_valid, in_signed, in_s, in_t, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_q, out_r, out_tag, out_dbz, out_ovf
  );
  modport slave (
    input  in_valid, in_signed, in_s, in_t, in_tag, flush, out_ready,
    output in_ready, out_valid, out_q, out_r, out_tag, out_dbz, out_ovf
  );
`else
  modport master (
    output in_valid, in_signed, in_s, in_t, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_q, out_r, out_tag
  );
  modport slave (
    input  in_valid, in_signed, in_s, in_t, in_tag, flush, out_ready,
    output in_ready, out_valid, out_q, out_r, out_tag
  );
`endif
endinterface

// File: rtl/div_pipe.sv
// div_pipe: pipelined restoring divider, BPS quotient bits per stage, RISC-V dbz/ovf semantics
// DIV_PIPE_DBZ_FLAG_EN exposes the latched dbz/ovf flags on the interface.
module div_pipe #(
  parameter int WIDTH = 32,
  parameter int BPS = 4,
  parameter int TAG_W = 5
) (
  input logic clk,
  input logic rst,
  div_pipe_if.slave bus
);
  localparam int NSTAGE = WIDTH / BPS;
  localparam int W2 = 2 * WIDTH;
  logic [NSTAGE-1:0] v_r, nq_r, nr_r, dbz_r, ovf_r;
  logic [WIDTH-1:0] s_r [NSTAGE];
  logic [W2-1:0] t_r [NSTAGE];
  logic [WIDTH-1:0] q_r [NSTAGE];
  logic [TAG_W-1:0] tag_r [NSTAGE];
  logic stall, acc, s_neg, t_neg, ovf_in;
  logic [WIDTH-1:0] s_mag, t_mag, q_fix, r_fix;
  assign stall = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall && !bus.flush;
  assign acc = bus.in_valid && bus.in_ready;
  assign s_neg = bus.in_signed && bus.in_s[WIDTH-1];
  assign t_neg = bus.in_signed && bus.in_t[WIDTH-1];
  assign s_mag = s_neg ? -bus.in_s : bus.in_s;
  assign t_mag = t_neg ? -bus.in_t : bus.in_t;
  assign ovf_in = bus.in_signed && bus.in_s == {1'b1, {(WIDTH-1){1'b0}}} && &bus.in_t;
  for (genvar k = 0; k < NSTAGE; k++) begin : g_st
    logic v_i, nq_i, nr_i, dbz_i, ovf_i;
    logic [WIDTH-1:0] s_i, q_i, s_o, q_o;
    logic [W2-1:0] t_i, t_o;
    logic [TAG_W-1:0] tag_i;
    if (k == 0) begin : g_head
      assign {v_i, nq_i, nr_i, dbz_i, ovf_i} = {acc, s_neg ^ t_neg, s_neg, bus.in_t == '0, ovf_in};
      assign s_i = s_mag;
      assign t_i = {1'b0, t_mag, {(WIDTH-1){1'b0}}};
      assign q_i = '0;
      assign tag_i = bus.in_tag;
    end else begin : g_body
      assign {v_i, nq_i, nr_i, dbz_i, ovf_i} = {v_r[k-1], nq_r[k-1], nr_r[k-1], dbz_r[k-1], ovf_r[k-1]};
      assign s_i = s_r[k-1];
      assign t_i = t_r[k-1];
      assign q_i = q_r[k-1];
      assign tag_i = tag_r[k-1];
    end
    // remainder always fits WIDTH bits, so only t needs the double width
    always_comb begin
      s_o = s_i;
      t_o = t_i;
      q_o = q_i;
      for (int i = 0; i < BPS; i++) begin
        q_o = {q_o[WIDTH-2:0], {{WIDTH{1'b0}}, s_o} >= t_o};
        s_o = {{WIDTH{1'b0}}, s_o} >= t_o ? s_o - t_o[WIDTH-1:0] : s_o;
        t_o = t_o >> 1;
      end
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        v_r[k] <= 1'b0;
        {nq_r[k], nr_r[k], dbz_r[k], ovf_r[k]} <= '0;
        s_r[k] <= '0;
        t_r[k] <= '0;
        q_r[k] <= '0;
        tag_r[k] <= '0;
      end else if (bus.flush) begin
        v_r[k] <= 1'b0;
      end else if (!stall) begin
        v_r[k] <= v_i;
        if (v_i) begin
          {nq_r[k], nr_r[k], dbz_r[k], ovf_r[k]} <= {nq_i, nr_i, dbz_i, ovf_i};
          s_r[k] <= s_o;
          t_r[k] <= t_o;
          q_r[k] <= q_o;
          tag_r[k] <= tag_i;
        end
      end
    end
  end
  assign bus.out_valid = v_r[NSTAGE-1];
  assign bus.out_tag = tag_r[NSTAGE-1];
  assign q_fix = nq_r[NSTAGE-1] ? -q_r[NSTAGE-1] : q_r[NSTAGE-1];
  assign r_fix = nr_r[NSTAGE-1] ? -s_r[NSTAGE-1] : s_r[NSTAGE-1];
  assign bus.out_q = dbz_r[NSTAGE-1] ? '1 : ovf_r[NSTAGE-1] ? {1'b1, {(WIDTH-1){1'b0}}} : q_fix;
  assign bus.out_r = ovf_r[NSTAGE-1] ? '0 : r_fix;
`ifdef DIV_PIPE_DBZ_FLAG_EN
  assign bus.out_dbz = dbz_r[NSTAGE-1];
  assign bus.out_ovf = ovf_r[NSTAGE-1];
`endif
endmodule

// File: tb/tb_div_pipe.sv
// tb_div_pipe: directed and back-pressure checks of div_pipe against an arithmetic reference
module tb_div_pipe;
  localparam int NS = 8;
  typedef struct packed {
    logic v, dbz, ovf;
    logic [31:0] q, r;
    logic [4:0] tag;
  } res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0, n_err = 0, n_out = 0;
  res_t m [NS];
  logic prev_stall = 1'b0, stall_m;
  logic [31:0] hq, hr;
  logic [4:0] ht;
  div_pipe_if #(.WIDTH(32), .TAG_W(5)) bus ();
  div_pipe #(.WIDTH(32), .BPS(4), .TAG_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic res_t model(input logic sg, input logic [31:0] s, input logic [31:0] t, input logic [4:0] tg);
    res_t x;
    x.v = 1'b1;
    x.tag = tg;
    x.dbz = t == 0;
    x.ovf = sg && s == 32'h8000_0000 && t == 32'hFFFF_FFFF;
    if (x.dbz) begin x.q = '1; x.r = s; end
    else if (x.ovf) begin x.q = s; x.r = 0; end
    else if (sg) begin x.q = $signed(s) / $signed(t); x.r = $signed(s) % $signed(t); end
    else begin x.q = s / t; x.r = s % t; end
    return x;
  endfunction
  // reference pipeline: fixed depth, holds while the result is refused, cleared by flush/rst
  always @(posedge clk) begin
    if (rst || bus.flush) begin
      for (int i = 0; i < NS; i++) m[i] = '0;
    end else if (!(m[NS-1].v && !bus.out_ready)) begin
      for (int i = NS - 1; i > 0; i--) m[i] = m[i-1];
      m[0] = bus.in_valid ? model(bus.in_signed, bus.in_s, bus.in_t, bus.in_tag) : '0;
    end
  end
  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else begin
      stall_m = m[NS-1].v && !bus.out_ready;
      chk("out_valid", bus.out_valid, m[NS-1].v);
      chk("in_ready", bus.in_ready, !stall_m && !bus.flush);
      if (m[NS-1].v) begin
        chk("out_q", bus.out_q, m[NS-1].q);
        chk("out_r", bus.out_r, m[NS-1].r);
        chk("out_tag", bus.out_tag, m[NS-1].tag);
`ifdef DIV_PIPE_DBZ_FLAG_EN
        chk("out_dbz", bus.out_dbz, m[NS-1].dbz);
        chk("out_ovf", bus.out_ovf, m[NS-1].ovf);
`endif
      end
      if (prev_stall) begin
        chk("hold_q", bus.out_q, hq);
        chk("hold_r", bus.out_r, hr);
        chk("hold_tag", bus.out_tag, ht);
      end
      prev_stall = stall_m && !bus.flush;
      {hq, hr, ht} = {bus.out_q, bus.out_r, bus.out_tag};
      if (bus.out_valid && bus.out_ready) n_out++;
    end
  end
  task automatic drive(input logic vld, input logic sg, input logic [31:0] s, input logic [31:0] t, input logic [4:0] tg);
    bus.in_valid = vld;
    bus.in_signed = sg;
    bus.in_s = s;
    bus.in_t = t;
    bus.in_tag = tg;
  endtask
  task automatic op(input logic sg, input logic [31:0] s, input logic [31:0] t, input logic [4:0] tg,
                    input logic [31:0] eq, input logic [31:0] er);
    drive(1'b1, sg, s, t, tg);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("lat_early", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_valid", bus.out_valid, 1);
    chk("lit_q", bus.out_q, eq);
    chk("lit_r", bus.out_r, er);
    chk("lit_tag", bus.out_tag, tg);
    @(posedge clk);
    #1;
  endtask
  task automatic kill_test(input bit use_rst);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i[0], $urandom, $urandom_range(1, 1000), 5'(i + 20));
      @(posedge clk);
      #1;
    end
    if (use_rst) rst = 1'b1;
    else bus.flush = 1'b1;
    drive(1'b1, 1'b0, 32'd77, 32'd7, 5'd30);
    @(negedge clk);
    if (!use_rst) chk("flush_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.flush = 1'b0;
    drive(1'b1, 1'b0, 32'd1000, 32'd10, 5'd9);
    if (use_rst) begin
      @(negedge clk);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_ready", bus.in_ready, 1);
      chk("rst_q", bus.out_q, 0);
      chk("rst_r", bus.out_r, 0);
      chk("rst_tag", bus.out_tag, 0);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("kill_early", bus.out_valid, 0);
    @(negedge clk);
    chk("kill_valid", bus.out_valid, 1);
    chk("kill_q", bus.out_q, 100);
    chk("kill_r", bus.out_r, 0);
    chk("kill_tag", bus.out_tag, 9);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] bs [12], bt [12];
    logic bsg [12];
    int idx, n0;
    for (int i = 0; i < NS; i++) m[i] = '0;
    drive(1'b0, 1'b0, '0, '0, '0);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_ready", bus.in_ready, 1);
    chk("reset_q", bus.out_q, 0);
    chk("reset_r", bus.out_r, 0);
    chk("reset_tag", bus.out_tag, 0);
    @(posedge clk);
    #1;
    op(1'b0, 32'd100, 32'd7, 5'd3, 32'd14, 32'd2);
    op(1'b1, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    op(1'b1, 32'd7, 32'hFFFF_FFFE, 5'd5, 32'hFFFF_FFFD, 32'd1);
    op(1'b0, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'h7FFF_FFFC, 32'd1);
    op(1'b0, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 32'd5);
    op(1'b1, 32'hFFFF_FFFB, 32'd0, 5'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 32'd0);
    op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 32'h8000_0000);
    op(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 5'd12, 32'd2, 32'hFFFF_FFFE);
    op(1'b0, 32'hFFFF_FFFF, 32'd1, 5'd31, 32'hFFFF_FFFF, 32'd0);
    for (int i = 0; i < 12; i++) begin
      bsg[i] = i[0];
      bs[i] = $urandom;
      bt[i] = (i % 3 == 0) ? $urandom : $urandom_range(1, 50);
    end
    bt[5] = 32'd0;
    {bsg[7], bs[7], bt[7]} = {1'b1, 32'h8000_0000, 32'hFFFF_FFFF};
    idx = 0;
    n0 = n_out;
    for (int j = 0; j < 40; j++) begin
      bus.out_ready = !(j >= 9 && j <= 11);
      if (idx < 12) drive(1'b1, bsg[idx], bs[idx], bt[idx], 5'(idx));
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    chk("bp_accepted", 32'(idx), 12);
    chk("bp_results", 32'(n_out - n0), 12);
    kill_test(1'b0);
    kill_test(1'b1);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
